spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral_pkg.sv | 11 +
 rtl/sync_ff.sv | 24 ++
 rtl/spi_peripheral.sv | 188 ++++++++++++++++++
 tb/tb_spi_peripheral.sv | 138 +++++++++++++
 4 files changed

// File: rtl/spi_peripheral_pkg.sv
// Shared constants for the SPI register peripheral: frame layout and register map.
package spi_peripheral_pkg;
    localparam int FRAME_W = 16;
    localparam int CNT_W   = 5;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer with a per-instance reset value.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {STAGES{RST_VAL}};
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register peripheral (5 x 8-bit registers).
// Define SPI_READBACK_EN to add the cipo readback path.
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
`ifdef SPI_READBACK_EN
    , output logic     cipo
`endif
);
    localparam int SW = $clog2(SYNC_STAGES + 1);

    logic sclk_s, ncs_s, copi_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(ncs_s));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));

    logic               sclk_prev_q, ncs_prev_q;
    logic [SW-1:0]      settle_q, settle_d;
    logic               armed_q, armed_d;
    logic               active_q, active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [7:0]         out_lo_q, out_lo_d, out_hi_q, out_hi_d;
    logic [7:0]         pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
    logic [7:0]         duty_q, duty_d;
    logic               sclk_rise, ncs_fall, ncs_rise, settled;
`ifdef SPI_READBACK_EN
    logic               sclk_fall;
    logic               rd_q, rd_d, cipo_q, cipo_d;
    logic [7:0]         tx_q, tx_d;

    function automatic logic [7:0] reg_rd(input logic [6:0] addr,
                                          input logic [7:0] r0, input logic [7:0] r1,
                                          input logic [7:0] r2, input logic [7:0] r3,
                                          input logic [7:0] r4);
        logic [7:0] v;
        v = 8'h00;
        if (addr <= MAX_ADDR) begin
            case (addr)
                ADDR_EN_OUT_7_0:  v = r0;
                ADDR_EN_OUT_15_8: v = r1;
                ADDR_EN_PWM_7_0:  v = r2;
                ADDR_EN_PWM_15_8: v = r3;
                ADDR_PWM_DUTY:    v = r4;
                default:          v = 8'h00;
            endcase
        end
        return v;
    endfunction
`endif

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign settled   = (settle_q == SW'(SYNC_STAGES));

    always_comb begin
        settle_d = settled ? settle_q : settle_q + SW'(1);
        // Only accept a frame start after ncs has been seen high with real
        // synchronizer data, so a frame in flight at reset release is dropped.
        armed_d  = armed_q | (settled & ncs_s);
        active_d = active_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;
        pwm_lo_d = pwm_lo_q;
        pwm_hi_d = pwm_hi_q;
        duty_d   = duty_q;
`ifdef SPI_READBACK_EN
        rd_d     = rd_q;
        tx_d     = tx_q;
        cipo_d   = cipo_q;
`endif
        if (ncs_fall && armed_q) begin
            active_d = 1'b1;
            cnt_d    = '0;
            shreg_d  = '0;
`ifdef SPI_READBACK_EN
            rd_d     = 1'b0;
            cipo_d   = 1'b0;
`endif
        end else if (ncs_rise) begin
            active_d = 1'b0;
`ifdef SPI_READBACK_EN
            rd_d     = 1'b0;
            cipo_d   = 1'b0;
`endif
            if (active_q && cnt_q == CNT_W'(FRAME_W) && shreg_q[15] && shreg_q[14:8] <= MAX_ADDR) begin
                case (shreg_q[14:8])
                    ADDR_EN_OUT_7_0:  out_lo_d = shreg_q[7:0];
                    ADDR_EN_OUT_15_8: out_hi_d = shreg_q[7:0];
                    ADDR_EN_PWM_7_0:  pwm_lo_d = shreg_q[7:0];
                    ADDR_EN_PWM_15_8: pwm_hi_d = shreg_q[7:0];
                    ADDR_PWM_DUTY:    duty_d   = shreg_q[7:0];
                    default:          ;
                endcase
            end
        end else if (sclk_rise && active_q && !ncs_s && cnt_q < CNT_W'(FRAME_W)) begin
            shreg_d = {shreg_q[FRAME_W-2:0], copi_s};
            cnt_d   = cnt_q + CNT_W'(1);
`ifdef SPI_READBACK_EN
            if (cnt_q == CNT_W'(7) && !shreg_d[7]) begin
                rd_d = 1'b1;
                tx_d = reg_rd(shreg_d[6:0], out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q);
            end
`endif
        end
`ifdef SPI_READBACK_EN
        else if (sclk_fall && rd_q && active_q) begin
            if (cnt_q >= CNT_W'(8) && cnt_q < CNT_W'(FRAME_W)) begin
                cipo_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end else begin
                cipo_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            active_q    <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            out_lo_q    <= 8'h00;
            out_hi_q    <= 8'h00;
            pwm_lo_q    <= 8'h00;
            pwm_hi_q    <= 8'h00;
            duty_q      <= 8'h00;
        end else begin
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
            pwm_lo_q    <= pwm_lo_d;
            pwm_hi_q    <= pwm_hi_d;
            duty_q      <= duty_d;
        end
    end

`ifdef SPI_READBACK_EN
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= 1'b0;
            tx_q   <= 8'h00;
            cipo_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            tx_q   <= tx_d;
            cipo_q <= cipo_d;
        end
    end

    assign cipo = cipo_q;
`endif

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed self-checking bench for spi_peripheral (readback checked when SPI_READBACK_EN is defined).
module tb_spi_peripheral;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ncs = 1'b1;
    logic       copi = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
`ifdef SPI_READBACK_EN
    logic       cipo;
`endif
    logic [7:0] rx;
    int         checks = 0;
    int         errors = 0;

    spi_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .copi(copi),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
`ifdef SPI_READBACK_EN
        , .cipo(cipo)
`endif
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        check({tag, ".out_7_0"},  en_reg_out_7_0,  e0);
        check({tag, ".out_15_8"}, en_reg_out_15_8, e1);
        check({tag, ".pwm_7_0"},  en_reg_pwm_7_0,  e2);
        check({tag, ".pwm_15_8"}, en_reg_pwm_15_8, e3);
        check({tag, ".duty"},     pwm_duty_cycle,  e4);
    endtask

    task automatic cs_low();
        ncs = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_high();
        ncs = 1'b1;
        wait_clks(12);
    endtask

    // Sends data[n-1:0] MSB-first; captures cipo ahead of rising edges 9..16.
    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = data[i];
            wait_clks(HALF);
`ifdef SPI_READBACK_EN
            if ((n - i) >= 9 && (n - i) <= 16) rx = {rx[6:0], cipo};
`endif
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        wait_clks(HALF);
    endtask

    task automatic frame(input logic [15:0] data);
        cs_low();
        send_bits({16'h0, data}, 16);
        cs_high();
    endtask

    initial begin
        rx = 8'h00;
        wait_clks(4);
        check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        wait_clks(6);

        frame(16'h80F0);
        check_all("wr_addr0", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);

        frame(16'h84C8);
        frame(16'h82A5);
        check_all("wr_duty_pwm", 8'hF0, 8'h00, 8'hA5, 8'h00, 8'hC8);

`ifdef SPI_READBACK_EN
        rx = 8'h00;
        frame(16'h0400);
        check("readback_duty", rx, 8'hC8);
`endif

        frame(16'h8A55);
        frame(16'h01FF);
        check_all("oor_and_read", 8'hF0, 8'h00, 8'hA5, 8'h00, 8'hC8);

        cs_low();
        send_bits(32'h0000_0817, 12);
        cs_high();
        check("short_frame", en_reg_out_15_8, 8'h00);
        frame(16'h8133);
        check("full_after_short", en_reg_out_15_8, 8'h33);

        cs_low();
        send_bits({12'h0, 16'h8311, 4'hF}, 20);
        cs_high();
        check("extra_sclk", en_reg_pwm_15_8, 8'h11);

        frame(16'h84FF);
        check("pre_reset_duty", pwm_duty_cycle, 8'hFF);
        cs_low();
        send_bits(32'h0000_0084, 8);
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_clks(3);
        rst_n = 1'b1;
        send_bits(32'h0000_00EE, 8);
        cs_high();
        check_all("frame_across_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        frame(16'h8410);
        check_all("after_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
